// File: rtl/sbus_frame_decoder_pkg.sv
// Shared constants, flag bit positions and FSM encoding for the SBUS frame decoder.
package sbus_pkg;

  localparam logic [7:0] SBUS_HEADER = 8'h0F;
  localparam logic [7:0] SBUS_FOOTER = 8'h00;

  localparam int FLAG_CH17 = 0;
  localparam int FLAG_CH18 = 1;
  localparam int FLAG_LOST = 2;
  localparam int FLAG_FS   = 3;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_DATA   = 2'd1,
    ST_FLAGS  = 2'd2,
    ST_FOOTER = 2'd3
  } sbus_state_e;

  function automatic int sbus_data_bytes(input int num_ch, input int ch_bits);
    return (num_ch * ch_bits + 7) / 8;
  endfunction

endpackage

// File: rtl/sbus_frame_decoder_gap_timer.sv
// Inter-frame idle detector: gap_seen goes high once GAP_CYCLES clocks pass with no byte,
// and stays high until the next byte arrives.
module sbus_gap_timer #(
  parameter int GAP_CYCLES = 15000
) (
  input  logic clk,
  input  logic reset,
  input  logic byte_strobe,
  output logic gap_seen
);

  localparam int CNT_W = $clog2(GAP_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(GAP_CYCLES);

  // Down-counter holding the idle cycles still needed; zero is the saturated state.
  logic [CNT_W-1:0] remain_q, remain_d;

  always_comb begin
    remain_d = remain_q;
    if (byte_strobe) begin
      remain_d = LOAD;
    end else if (remain_q != '0) begin
      remain_d = remain_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      remain_q <= LOAD;
    end else begin
      remain_q <= remain_d;
    end
  end

  assign gap_seen = (remain_q == '0);

endmodule

// File: rtl/sbus_frame_decoder.sv
// SBUS receiver back end: gap-based frame hunt, header/footer/byte-error checks,
// channel unpacking and flag decode with saturating error counters.
//
//   state     | meaning
//   ST_HUNT   | waiting for a header after a gap or right after a good frame
//   ST_DATA   | collecting the packed channel bytes
//   ST_FLAGS  | next byte is the flags byte
//   ST_FOOTER | next byte must be the footer; a good one commits the frame
module sbus_frame_decoder
  import sbus_pkg::*;
#(
  parameter int          NUM_CH     = 16,
  parameter int          CH_BITS    = 11,
  parameter int          GAP_CYCLES = 15000,
  parameter logic [7:0]  HEADER     = SBUS_HEADER,
  parameter logic [7:0]  FOOTER     = SBUS_FOOTER,
  parameter int          ERR_W      = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       uart_rx_valid,
  input  logic                       uart_rx_fe,
  input  logic                       uart_rx_pe,
  input  logic [7:0]                 uart_rx_data,
  output logic [NUM_CH*CH_BITS-1:0]  ch_data,
  output logic                       ch17,
  output logic                       ch18,
  output logic                       frame_lost,
  output logic                       failsafe,
  output logic                       frame_valid,
  output logic                       in_sync,
  output logic [ERR_W-1:0]           err_byte_cnt,
  output logic [ERR_W-1:0]           err_frame_cnt
);

  localparam int DATA_BYTES = sbus_data_bytes(NUM_CH, CH_BITS);
  localparam int CH_W       = NUM_CH * CH_BITS;
  localparam int STG_W      = DATA_BYTES * 8;
  localparam int IDX_W      = $clog2(DATA_BYTES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BYTES - 1);

  logic gap_seen;

  sbus_gap_timer #(
    .GAP_CYCLES (GAP_CYCLES)
  ) u_gap_timer (
    .clk         (clk),
    .reset       (reset),
    .byte_strobe (uart_rx_valid),
    .gap_seen    (gap_seen)
  );

  sbus_state_e       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CH_W-1:0]   staging_q, staging_d;
  logic [3:0]        flags_stage_q, flags_stage_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [3:0]        flags_q, flags_d;
  logic              fv_q, fv_d;
  logic              sync_q, sync_d;
  logic              ok_prev_q, ok_prev_d;
  logic [ERR_W-1:0]  err_byte_q, err_byte_d;
  logic [ERR_W-1:0]  err_frame_q, err_frame_d;

  logic              byte_err;
  logic [STG_W-1:0]  stage_wide;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == '1) ? v : v + ERR_W'(1);
  endfunction

  assign byte_err = uart_rx_fe | uart_rx_pe;

  // Padding bits of the last data byte fall off when the byte-wide view is narrowed back.
  always_comb begin
    stage_wide = STG_W'(staging_q);
    for (int b = 0; b < DATA_BYTES; b++) begin
      if (idx_q == IDX_W'(b)) begin
        stage_wide[b*8 +: 8] = uart_rx_data;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    staging_d     = staging_q;
    flags_stage_d = flags_stage_q;
    ch_d          = ch_q;
    flags_d       = flags_q;
    fv_d          = 1'b0;
    sync_d        = sync_q;
    ok_prev_d     = ok_prev_q;
    err_byte_d    = err_byte_q;
    err_frame_d   = err_frame_q;

    if (uart_rx_valid) begin
      ok_prev_d = 1'b0;
      if (state_q != ST_HUNT && byte_err) begin
        err_byte_d = sat_inc(err_byte_q);
        sync_d     = 1'b0;
        state_d    = ST_HUNT;
      end else begin
        case (state_q)
          ST_HUNT: begin
            if (uart_rx_data == HEADER && !byte_err && (gap_seen || ok_prev_q)) begin
              state_d = ST_DATA;
              idx_d   = '0;
            end
          end
          ST_DATA: begin
            staging_d = CH_W'(stage_wide);
            if (idx_q == LAST_IDX) begin
              state_d = ST_FLAGS;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
          ST_FLAGS: begin
            flags_stage_d = uart_rx_data[3:0];
            state_d       = ST_FOOTER;
          end
          ST_FOOTER: begin
            if (uart_rx_data == FOOTER) begin
              ch_d      = staging_q;
              flags_d   = flags_stage_q;
              fv_d      = 1'b1;
              sync_d    = 1'b1;
              ok_prev_d = 1'b1;
            end else begin
              err_frame_d = sat_inc(err_frame_q);
              sync_d      = 1'b0;
            end
            state_d = ST_HUNT;
          end
          default: state_d = ST_HUNT;
        endcase
      end
    end else if (gap_seen && state_q != ST_HUNT) begin
      err_frame_d = sat_inc(err_frame_q);
      sync_d      = 1'b0;
      state_d     = ST_HUNT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_HUNT;
      idx_q         <= '0;
      staging_q     <= '0;
      flags_stage_q <= '0;
      ch_q          <= '0;
      flags_q       <= '0;
      fv_q          <= 1'b0;
      sync_q        <= 1'b0;
      ok_prev_q     <= 1'b0;
      err_byte_q    <= '0;
      err_frame_q   <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      staging_q     <= staging_d;
      flags_stage_q <= flags_stage_d;
      ch_q          <= ch_d;
      flags_q       <= flags_d;
      fv_q          <= fv_d;
      sync_q        <= sync_d;
      ok_prev_q     <= ok_prev_d;
      err_byte_q    <= err_byte_d;
      err_frame_q   <= err_frame_d;
    end
  end

  assign ch_data       = ch_q;
  assign ch17          = flags_q[FLAG_CH17];
  assign ch18          = flags_q[FLAG_CH18];
  assign frame_lost    = flags_q[FLAG_LOST];
  assign failsafe      = flags_q[FLAG_FS];
  assign frame_valid   = fv_q;
  assign in_sync       = sync_q;
  assign err_byte_cnt  = err_byte_q;
  assign err_frame_cnt = err_frame_q;

endmodule

// File: tb/tb_sbus_frame_decoder.sv
// Randomized frame-level bench for sbus_frame_decoder: a 16-channel and an 8-channel build
// checked against a frame-outcome reference model.
module tb_sbus_frame_decoder;

  localparam int GAP = 40;
  localparam int CHB = 11;
  localparam int NA  = 16;
  localparam int NB  = 8;
  localparam int K_GOOD = 0, K_BYTE = 1, K_FOOT = 2, K_TRUNC = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic v[2], fe[2], pe[2];
  logic [7:0] d[2];
  logic [NA*CHB-1:0] ch_a;
  logic [NB*CHB-1:0] ch_b;
  logic c17[2], c18[2], lost[2], fs[2], fv[2], sync[2];
  logic [7:0] be_cnt[2], fr_cnt[2];

  always #5 clk = ~clk;

  sbus_frame_decoder #(
    .NUM_CH(NA), .CH_BITS(CHB), .GAP_CYCLES(GAP), .HEADER(8'h0F), .FOOTER(8'h00), .ERR_W(8)
  ) dut_a (
    .clk(clk), .reset(reset), .uart_rx_valid(v[0]), .uart_rx_fe(fe[0]), .uart_rx_pe(pe[0]),
    .uart_rx_data(d[0]), .ch_data(ch_a), .ch17(c17[0]), .ch18(c18[0]), .frame_lost(lost[0]),
    .failsafe(fs[0]), .frame_valid(fv[0]), .in_sync(sync[0]), .err_byte_cnt(be_cnt[0]),
    .err_frame_cnt(fr_cnt[0])
  );

  sbus_frame_decoder #(
    .NUM_CH(NB), .CH_BITS(CHB), .GAP_CYCLES(GAP), .HEADER(8'h0F), .FOOTER(8'h00), .ERR_W(8)
  ) dut_b (
    .clk(clk), .reset(reset), .uart_rx_valid(v[1]), .uart_rx_fe(fe[1]), .uart_rx_pe(pe[1]),
    .uart_rx_data(d[1]), .ch_data(ch_b), .ch17(c17[1]), .ch18(c18[1]), .frame_lost(lost[1]),
    .failsafe(fs[1]), .frame_valid(fv[1]), .in_sync(sync[1]), .err_byte_cnt(be_cnt[1]),
    .err_frame_cnt(fr_cnt[1])
  );

  int n_chk = 0;
  int n_pass = 0;
  int pulses[2] = '{0, 0};
  int force_k = -1;

  logic [175:0] m_ch[2];
  logic [3:0]   m_fl[2];
  int           m_be[2], m_fe[2];
  bit           m_sync[2], m_okp[2], m_gap[2];

  logic [7:0]   fr[$];
  logic [175:0] cur_ch;
  logic [3:0]   cur_fl;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) if (fv[i] === 1'b1) pulses[i]++;
  end

  task automatic chk(input string tag, input logic [175:0] got, input logic [175:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [175:0] obs_ch(input int s);
    return (s != 0) ? {88'b0, ch_b} : ch_a;
  endfunction

  function automatic logic [3:0] obs_fl(input int s);
    return {fs[s], lost[s], c18[s], c17[s]};
  endfunction

  function automatic int sat(input int x);
    return (x >= 255) ? 255 : x + 1;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_ch[s] = '0; m_fl[s] = '0; m_be[s] = 0; m_fe[s] = 0;
      m_sync[s] = 0; m_okp[s] = 0; m_gap[s] = 0;
    end
  endtask

  task automatic check_all(input int s);
    chk($sformatf("ch_data[%0d]", s), obs_ch(s), m_ch[s]);
    chk($sformatf("flags[%0d]", s), obs_fl(s), m_fl[s]);
    chk($sformatf("in_sync[%0d]", s), sync[s], m_sync[s]);
    chk($sformatf("err_byte[%0d]", s), be_cnt[s], m_be[s]);
    chk($sformatf("err_frame[%0d]", s), fr_cnt[s], m_fe[s]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    if (n >= GAP + 2) begin
      m_gap[0] = 1; m_gap[1] = 1;
    end
  endtask

  task automatic send_byte(input int s, input logic [7:0] b, input bit f, input bit p);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    v[s] = 1'b1; d[s] = b; fe[s] = f; pe[s] = p;
    @(negedge clk);
    v[s] = 1'b0; fe[s] = 1'b0; pe[s] = 1'b0;
    m_gap[s] = 0;
  endtask

  // Frame image from channel values: little-endian bit stream, byte0 bit0 = ch0 bit0.
  task automatic build(input int s, input bit directed);
    int nch, db;
    logic [7:0]  bytes[32];
    logic [10:0] val;
    logic [7:0]  fb;
    nch = (s == 0) ? NA : NB;
    db  = (nch * CHB + 7) / 8;
    cur_ch = '0;
    for (int i = 0; i < nch; i++) begin
      val = directed ? ((i == nch - 1) ? 11'h7FF : 11'(i)) : 11'($urandom_range(0, 2047));
      for (int b = 0; b < CHB; b++) cur_ch[i*CHB + b] = val[b];
    end
    for (int j = 0; j < 32; j++) bytes[j] = 8'h00;
    for (int b = 0; b < nch * CHB; b++) bytes[b/8][b%8] = cur_ch[b];
    fb = directed ? 8'h0C : 8'($urandom);
    cur_fl = fb[3:0];
    fr.delete();
    fr.push_back(8'h0F);
    for (int j = 0; j < db; j++) fr.push_back(bytes[j]);
    fr.push_back(fb);
    fr.push_back(8'h00);
  endtask

  task automatic run_frame(input int s, input int kind, input bit gap_before);
    bit accept, errf;
    int n, k, p0, exp_p;
    if (gap_before) idle(GAP + 3);
    accept = m_gap[s] || m_okp[s];
    n = fr.size();
    k = (force_k >= 0) ? force_k : int'($urandom_range(1, n - 1));
    if (kind == K_FOOT) fr[n-1] = (force_k >= 0) ? 8'h55 : 8'($urandom_range(1, 255));
    errf = 1'($urandom_range(0, 1));
    p0 = pulses[s];
    for (int i = 0; i < n; i++) begin
      if (!(kind == K_TRUNC && i >= k))
        send_byte(s, fr[i], kind == K_BYTE && i == k && errf, kind == K_BYTE && i == k && !errf);
    end
    if (kind == K_GOOD && accept) chk("frame_valid_latency", fv[s], 1'b1);
    if (kind == K_TRUNC) idle(GAP + 3);
    exp_p = 0;
    if (accept) begin
      case (kind)
        K_GOOD: begin
          m_ch[s] = cur_ch; m_fl[s] = cur_fl; m_sync[s] = 1; exp_p = 1;
        end
        K_BYTE: begin
          m_be[s] = sat(m_be[s]); m_sync[s] = 0;
        end
        default: begin
          m_fe[s] = sat(m_fe[s]); m_sync[s] = 0;
        end
      endcase
    end
    m_okp[s] = accept && (kind == K_GOOD);
    @(negedge clk);
    #1;
    chk($sformatf("pulses[%0d]", s), pulses[s] - p0, exp_p);
    check_all(s);
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      v[s] = 1'b0; fe[s] = 1'b0; pe[s] = 1'b0; d[s] = 8'h00;
    end
    model_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_all(0);
    check_all(1);
    chk("frame_valid_rst", fv[0], 1'b0);
    reset = 1'b0;

    build(0, 1);
    run_frame(0, K_GOOD, 0);
    run_frame(0, K_GOOD, 1);
    chk("failsafe", fs[0], 1'b1);
    chk("frame_lost", lost[0], 1'b1);
    chk("ch17", c17[0], 1'b0);

    build(0, 0);
    run_frame(0, K_GOOD, 0);
    force_k = 10;
    build(0, 0);
    run_frame(0, K_BYTE, 0);
    build(0, 0);
    run_frame(0, K_FOOT, 1);
    force_k = 13;
    build(0, 0);
    run_frame(0, K_TRUNC, 1);
    force_k = -1;
    build(0, 1);
    run_frame(0, K_GOOD, 0);

    for (int t = 0; t < 60; t++) begin
      int r;
      r = int'($urandom_range(0, 5));
      build(0, 0);
      run_frame(0, (r <= 2) ? K_GOOD : r - 2, 1'($urandom_range(0, 1)));
    end

    for (int t = 0; t < 300; t++) begin
      build(0, 0);
      run_frame(0, K_BYTE, 1);
    end
    chk("err_byte_saturated", be_cnt[0], 8'd255);

    build(1, 1);
    run_frame(1, K_GOOD, 1);
    for (int t = 0; t < 20; t++) begin
      int r;
      r = int'($urandom_range(0, 5));
      build(1, 0);
      run_frame(1, (r <= 2) ? K_GOOD : r - 2, 1'($urandom_range(0, 1)));
    end

    idle(GAP + 3);
    build(1, 0);
    for (int i = 0; i < 6; i++) send_byte(1, fr[i], 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    #1;
    model_reset();
    check_all(0);
    check_all(1);
    chk("frame_valid_midreset", fv[1], 1'b0);
    reset = 1'b0;
    build(1, 0);
    run_frame(1, K_GOOD, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
